// File: rtl/prbs31_checker.sv
// ---------------------------------------------------------------------------
// prbs31_checker
//   Serial PRBS31 (x^31 + x^28 + 1) bit-error checker for link and loopback
//   BER testing. A local history register is seeded from the received bits.
//   The predictor must then be right LOCK_N times in a row before the checker
//   declares lock. Once locked, the history free-runs on its own predictions,
//   and every received bit that disagrees with the prediction is counted as
//   one error.
//
// Ports
//   clk        in   1      clock, all state on the rising edge
//   rst_n      in   1      asynchronous reset, active-high
//   rx_valid   in   1      qualifies rx_bit; all state holds while low
//   rx_bit     in   1      received PRBS bit
//   clr_cnt    in   1      synchronous clear of err_count
//   locked     out  1      checker is in the LOCKED state
//   err_pulse  out  1      one-cycle pulse per mismatched bit while locked
//   err_count  out  ERR_W  saturating error count since reset or clear
//   state_o    out  2      0 SEED, 1 VERIFY, 2 LOCKED
// ---------------------------------------------------------------------------
module prbs31_checker #(
    parameter int LOCK_N      = 64,
    parameter int WIN_LEN     = 256,
    parameter int UNLOCK_ERRS = 8,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic             rx_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int MATCH_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_N - 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(32'd1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(32'd1);
    localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(UNLOCK_ERRS);
    localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0]   ERR_ONE    = ERR_W'(32'd1);
    localparam logic [4:0]         SEED_LAST  = 5'd30;

    // Next bit of the stream from the history (h[0] newest): b[m-28] ^ b[m-31].
    function automatic logic prbs_predict(input logic [30:0] hist);
        return hist[27] ^ hist[30];
    endfunction

    state_e               state_q,     state_d;
    logic [30:0]          hist_q,      hist_d;
    logic [4:0]           seed_cnt_q,  seed_cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]     win_cnt_q,   win_cnt_d;
    logic [WERR_W-1:0]    win_err_q,   win_err_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic                 locked_q;

    logic [30:0]          shifted_s;
    logic                 pred_s;
    logic                 bit_err_s;
    logic [WERR_W-1:0]    win_base_s;

    // Next-state decode for one received bit
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        // Clear is applied before any increment in the same cycle.
        err_count_d = clr_cnt ? {ERR_W{1'b0}} : err_count_q;
        shifted_s   = {hist_q[29:0], rx_bit};
        pred_s      = prbs_predict(hist_q);
        bit_err_s   = 1'b0;
        win_base_s  = {WERR_W{1'b0}};

        if (rx_valid) begin
            case (state_q)
                ST_SEED: begin
                    hist_d = shifted_s;
                    if (seed_cnt_q == SEED_LAST) begin
                        seed_cnt_d = 5'd0;
                        // An all-zero history is a fixed point of the LFSR and
                        // would "predict" a stuck-at-0 line forever, so reseed.
                        if (shifted_s != 31'd0) begin
                            state_d     = ST_VERIFY;
                            match_cnt_d = {MATCH_W{1'b0}};
                        end else begin
                            state_d = ST_SEED;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                ST_VERIFY: begin
                    hist_d = shifted_s;
                    if (rx_bit == pred_s) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = {MATCH_W{1'b0}};
                            win_cnt_d   = {WIN_W{1'b0}};
                            win_err_d   = {WERR_W{1'b0}};
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_ONE;
                        end
                    end else begin
                        state_d     = ST_SEED;
                        seed_cnt_d  = 5'd0;
                        match_cnt_d = {MATCH_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so a flipped input bit never
                    // enters the history and is counted exactly once.
                    hist_d     = {hist_q[29:0], pred_s};
                    bit_err_s  = rx_bit ^ pred_s;
                    win_base_s = (win_cnt_q == {WIN_W{1'b0}}) ? {WERR_W{1'b0}} : win_err_q;
                    win_err_d  = win_base_s + WERR_W'(bit_err_s);
                    win_cnt_d  = (win_cnt_q == WIN_LAST) ? {WIN_W{1'b0}} : (win_cnt_q + WIN_ONE);
                    if (bit_err_s) begin
                        err_pulse_d = 1'b1;
                        if (err_count_d != ERR_MAX) begin
                            err_count_d = err_count_d + ERR_ONE;
                        end else begin
                            err_count_d = ERR_MAX;
                        end
                    end else begin
                        err_pulse_d = 1'b0;
                    end
                    if (win_err_d == WERR_LIMIT) begin
                        state_d     = ST_SEED;
                        seed_cnt_d  = 5'd0;
                        match_cnt_d = {MATCH_W{1'b0}};
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d     = ST_SEED;
                    seed_cnt_d  = 5'd0;
                    match_cnt_d = {MATCH_W{1'b0}};
                end
            endcase
        end else begin
            err_pulse_d = 1'b0;
        end
    end

    // State registers and registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_SEED;
            hist_q      <= 31'd0;
            seed_cnt_q  <= 5'd0;
            match_cnt_q <= {MATCH_W{1'b0}};
            win_cnt_q   <= {WIN_W{1'b0}};
            win_err_q   <= {WERR_W{1'b0}};
            err_pulse_q <= 1'b0;
            err_count_q <= {ERR_W{1'b0}};
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            locked_q    <= (state_d == ST_LOCKED);
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker. A 16-bit-counter instance and a
// 4-bit-counter instance (to reach saturation) share one stimulus stream.
module tb_prbs31_checker;

    localparam int LOCK_N      = 64;
    localparam int WIN_LEN     = 256;
    localparam int UNLOCK_ERRS = 8;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic        rx_bit;
    logic        clr_cnt;
    logic        locked,   err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state_o;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_count_s;
    logic [1:0]  state_s;

    int total;
    int bad;

    // Reference model: mode 0 SEED, 1 VERIFY, 2 LOCKED.
    int     m_mode, m_seed, m_match, m_n, m_werr;
    bit     m_hist[$];   // last 31 stream bits, oldest first
    bit     m_pulse;
    longint m_cnt, m_cnt_s;
    bit     gen_q[$];    // generator history, oldest first

    prbs31_checker #(.LOCK_N(LOCK_N), .WIN_LEN(WIN_LEN), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_o(state_o));

    prbs31_checker #(.LOCK_N(LOCK_N), .WIN_LEN(WIN_LEN), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .state_o(state_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic gen_reset();
        gen_q.delete();
        for (int i = 0; i < 31; i++) gen_q.push_back(i == 30);
    endtask

    function automatic bit gen_next();
        bit nb;
        nb = gen_q[3] ^ gen_q[0];   // b[m-28] ^ b[m-31]
        gen_q.push_back(nb);
        void'(gen_q.pop_front());
        return nb;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_seed = 0; m_match = 0; m_n = 0; m_werr = 0;
        m_pulse = 1'b0; m_cnt = 0; m_cnt_s = 0;
        m_hist.delete();
        for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_push(input bit x);
        m_hist.push_back(x);
        void'(m_hist.pop_front());
    endtask

    function automatic bit hist_nonzero();
        foreach (m_hist[i]) if (m_hist[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit v, input bit b, input bit c);
        bit p;
        bit e;
        m_pulse = 1'b0;
        if (c) begin
            m_cnt = 0;
            m_cnt_s = 0;
        end
        if (v) begin
            p = m_hist[3] ^ m_hist[0];
            if (m_mode == 0) begin
                model_push(b);
                m_seed++;
                if (m_seed == 31) begin
                    m_seed = 0;
                    if (hist_nonzero()) begin
                        m_mode = 1;
                        m_match = 0;
                    end
                end
            end else if (m_mode == 1) begin
                model_push(b);
                if (b == p) begin
                    m_match++;
                    if (m_match == LOCK_N) begin
                        m_mode = 2;
                        m_n = 0;
                        m_werr = 0;
                    end
                end else begin
                    m_mode = 0; m_seed = 0; m_match = 0;
                end
            end else begin
                model_push(p);
                e = (b != p);
                // Windows are consecutive blocks of WIN_LEN bits since lock.
                if (m_n % WIN_LEN == 0) m_werr = 0;
                m_n++;
                if (e) begin
                    m_pulse = 1'b1;
                    m_werr++;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt_s < 15) m_cnt_s++;
                end
                if (m_werr == UNLOCK_ERRS) begin
                    m_mode = 0; m_seed = 0; m_match = 0;
                end
            end
        end
    endtask

    task automatic tick(input bit v, input bit b, input bit c);
        rx_valid = v;
        rx_bit   = b;
        clr_cnt  = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        check_eq("locked", longint'(locked), longint'(m_mode == 2));
        check_eq("state_o", longint'(state_o), longint'(m_mode));
        check_eq("err_pulse", longint'(err_pulse), longint'(m_pulse));
        check_eq("err_count", longint'(err_count), m_cnt);
        check_eq("err_count_sat", longint'(err_count_s), m_cnt_s);
        clr_cnt = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_eq("rst_locked", longint'(locked), 0);
        check_eq("rst_state", longint'(state_o), 0);
        check_eq("rst_err_pulse", longint'(err_pulse), 0);
        check_eq("rst_err_count", longint'(err_count), 0);
        check_eq("rst_err_count_sat", longint'(err_count_s), 0);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic align_window();
        for (int k = 0; k < 2 * WIN_LEN && (m_n % WIN_LEN) != 0; k++) tick(1'b1, gen_next(), 1'b0);
    endtask

    initial begin
        int  lock_at, relock, pulses, nvalid;
        bit  dropped, saw_lock, saw_verify, b, v;
        total = 0; bad = 0;
        rst_n = 1'b1; rx_valid = 1'b0; rx_bit = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_locked", longint'(locked), 0);
        check_eq("reset_state", longint'(state_o), 0);
        check_eq("reset_err_pulse", longint'(err_pulse), 0);
        check_eq("reset_err_count", longint'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b0;

        // Clean stream: lock right after bit 95, no errors.
        gen_reset();
        lock_at = 0;
        for (int i = 1; i <= 10000; i++) begin
            tick(1'b1, gen_next(), 1'b0);
            if (lock_at == 0 && locked) lock_at = i;
        end
        check_eq("p1_lock_bit", lock_at, 95);
        check_eq("p1_err_count", longint'(err_count), 0);

        // One flipped bit while locked.
        pulses = 0; dropped = 1'b0;
        tick(1'b1, !gen_next(), 1'b0);
        pulses += int'(err_pulse);
        for (int i = 0; i < 1000; i++) begin
            tick(1'b1, gen_next(), 1'b0);
            pulses += int'(err_pulse);
            if (!locked) dropped = 1'b1;
        end
        check_eq("p2_pulses", pulses, 1);
        check_eq("p2_err_count", longint'(err_count), 1);
        check_eq("p2_dropped", longint'(dropped), 0);

        // Eight errors inside one window force loss of lock, then relock.
        align_window();
        for (int j = 0; j <= 140; j++) begin
            b = gen_next();
            tick(1'b1, (j % 20 == 0) ? !b : b, 1'b0);
            if (j == 120) check_eq("p3_locked_after_7", longint'(locked), 1);
        end
        check_eq("p3_unlocked", longint'(locked), 0);
        check_eq("p3_err_count", longint'(err_count), 9);
        relock = 0;
        for (int k = 1; k <= 400 && relock == 0; k++) begin
            tick(1'b1, gen_next(), 1'b0);
            if (locked) relock = k;
        end
        check_eq("p3_relock_bits", relock, 95);

        // Clear, then seven errors per window for four windows.
        tick(1'b1, gen_next(), 1'b1);
        check_eq("p4_clr", longint'(err_count), 0);
        align_window();
        pulses = 0; dropped = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < WIN_LEN; j++) begin
                b = gen_next();
                tick(1'b1, (j % 32 == 5 && j < 224) ? !b : b, 1'b0);
                pulses += int'(err_pulse_s);
                if (!locked) dropped = 1'b1;
            end
        end
        check_eq("p4_dropped", longint'(dropped), 0);
        check_eq("p4_err_count", longint'(err_count), 28);
        check_eq("p4_err_count_saturated", longint'(err_count_s), 15);
        check_eq("p4_pulses_while_saturated", pulses, 28);

        // Stuck-at inputs never lock.
        async_reset();
        saw_lock = 1'b0; saw_verify = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (locked || state_o == 2'd2) saw_lock = 1'b1;
        end
        for (int i = 0; i < 5000; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (locked || state_o == 2'd2) saw_lock = 1'b1;
            if (state_o == 2'd1) saw_verify = 1'b1;
        end
        check_eq("p5_never_locked", longint'(saw_lock), 0);
        check_eq("p5_saw_verify", longint'(saw_verify), 1);

        // Random rx_valid gaps, clear with error, reset while locked.
        async_reset();
        gen_reset();
        nvalid = 0; lock_at = 0;
        for (int k = 0; k < 1000 && lock_at == 0; k++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                tick(1'b1, gen_next(), 1'b0);
                nvalid++;
            end else begin
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (lock_at == 0 && locked) lock_at = nvalid;
        end
        check_eq("p6_lock_valid_bits", lock_at, 95);
        for (int k = 0; k < 50; k++) begin
            v = 1'($urandom_range(0, 1));
            if (v) tick(1'b1, gen_next(), 1'b0);
            else tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        b = gen_next();
        tick(1'b1, !b, 1'b1);
        check_eq("p6_clr_plus_err", longint'(err_count), 1);
        check_eq("p6_clr_plus_err_sat", longint'(err_count_s), 1);
        check_eq("p6_pulse", longint'(err_pulse), 1);
        check_eq("p6_locked_before_rst", longint'(locked), 1);
        async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
